// File: rtl/apb_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_pkg
// Description : Shared types and helpers for the APB register file.
//               - apb_state_t : slave handshake state (IDLE, WAIT, RESP)
//               - idx_width   : register index width, clog2(max(n,2))
//               - byte_merge  : per-byte strobe merge of write data into
//                               an existing word
// Revision    : 1.0 - initial release
// ============================================================================
package apb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_t;

  // byte_merge operates on the widest supported word; callers size-cast
  // their operands in and the result back out.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic int idx_width(input int reg_num);
    return (reg_num <= 2) ? 1 : $clog2(reg_num);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] wdata,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_if
// Description : APB3 slave front end for the register file. Decodes the byte
//               address into a register index, flags out-of-range and
//               read-only accesses, runs the one-wait-state handshake and
//               hands a latched write request to the register array.
// Ports       : clk, reset                 - clock, sync active-high reset
//               psel/penable/pwrite/paddr/
//               pwdata/pstrb               - APB request
//               prdata/pready/pslverr      - APB response (registered)
//               regs                       - flattened register contents
//               wr_commit                  - write commits at this edge
//               wr_idx/wr_data/wr_strb     - latched write request
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_if
  import apb_reg_pkg::*;
#(
  parameter int                ADDR_WIDTH = 12,
  parameter int                DATA_WIDTH = 32,
  parameter int                REG_NUM    = 8,
  parameter logic [REG_NUM-1:0] RO_MASK   = '0,
  localparam int               IDX_W      = idx_width(REG_NUM),
  localparam int               STRB_W     = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [STRB_W-1:0]             pstrb,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pready,
  output logic                          pslverr,
  input  logic [REG_NUM*DATA_WIDTH-1:0] regs,
  output logic                          wr_commit,
  output logic [IDX_W-1:0]              wr_idx,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [STRB_W-1:0]             wr_strb
);

  localparam int OFF_W   = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int LIMIT_W = ADDR_WIDTH + 1;
  // One extra bit so a limit equal to 2**ADDR_WIDTH is still representable.
  localparam logic [LIMIT_W-1:0] ADDR_LIMIT = LIMIT_W'(REG_NUM * STRB_W);

  apb_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic                  out_of_range;
  logic                  ro_hit;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  lat_write;
  logic                  lat_err;
  logic [DATA_WIDTH-1:0] reg_arr [REG_NUM];

  for (genvar g = 0; g < REG_NUM; g++) begin : g_unpack
    assign reg_arr[g] = regs[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Unaligned low address bits are dropped; idx is only meaningful when the
  // address is in range, so every use of it is qualified by out_of_range.
  assign idx          = IDX_W'(paddr >> OFF_W);
  assign out_of_range = ({1'b0, paddr} >= ADDR_LIMIT);
  assign ro_hit       = !out_of_range && RO_MASK[idx];
  assign err          = out_of_range || (pwrite && ro_hit);
  assign rd_word      = out_of_range ? '0 : reg_arr[idx];

  // The write lands on the edge that closes RESP, so regs_out shows it one
  // cycle after pready.
  assign wr_commit = (state == ST_RESP) && lat_write && !lat_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (psel && penable) begin
            lat_write <= pwrite;
            lat_err   <= err;
            wr_idx    <= idx;
            wr_data   <= pwdata;
            wr_strb   <= pstrb;
            // Sampled before this edge's register updates: a hardware write
            // on the same edge is not reflected in the read data.
            prdata    <= pwrite ? '0 : rd_word;
            pready    <= 1'b1;
            pslverr   <= err;
            state     <= ST_RESP;
          end else if (!psel) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : apb_register_file
// Description : Parametrised APB3 register file with a hardware-side write
//               port. All registers are exported on a flattened bus. APB
//               writes take precedence over hardware writes to the same
//               register; a dropped hardware write raises hw_collision.
// Ports       : clk, reset                 - clock, sync active-high reset
//               psel..pstrb                - APB request
//               prdata/pready/pslverr      - APB response
//               hw_wen/hw_addr/hw_wdata/
//               hw_wstrb                   - hardware write port
//               regs_out                   - flattened register contents
//               reg_wr_pulse               - per-register APB write pulse
//               hw_collision               - hardware write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module apb_register_file
  import apb_reg_pkg::*;
#(
  parameter int                           ADDR_WIDTH  = 12,
  parameter int                           DATA_WIDTH  = 32,
  parameter int                           REG_NUM     = 8,
  parameter logic [REG_NUM-1:0]           RO_MASK     = '0,
  parameter logic [REG_NUM*DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                          IDX_W       = idx_width(REG_NUM),
  localparam int                          STRB_W      = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [STRB_W-1:0]             pstrb,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pready,
  output logic                          pslverr,
  input  logic                          hw_wen,
  input  logic [IDX_W-1:0]              hw_addr,
  input  logic [DATA_WIDTH-1:0]         hw_wdata,
  input  logic [STRB_W-1:0]             hw_wstrb,
  output logic [REG_NUM*DATA_WIDTH-1:0] regs_out,
  output logic [REG_NUM-1:0]            reg_wr_pulse,
  output logic                          hw_collision
);

  logic                  wr_commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  hw_in_range;
  logic                  hw_valid;
  logic [REG_NUM-1:0]    apb_hit_vec;

  apb_slave_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .RO_MASK    (RO_MASK)
  ) u_slave (
    .clk       (clk),
    .reset     (reset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .regs      (regs_out),
    .wr_commit (wr_commit),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
  );

  // When REG_NUM fills the index space every hardware address is valid;
  // otherwise indices at or above REG_NUM are silently ignored.
  if (REG_NUM == (2 ** IDX_W)) begin : g_hw_full
    assign hw_in_range = 1'b1;
  end else begin : g_hw_partial
    localparam logic [IDX_W:0] HW_LIMIT = (IDX_W + 1)'(REG_NUM);
    assign hw_in_range = ({1'b0, hw_addr} < HW_LIMIT);
  end

  assign hw_valid = hw_wen && hw_in_range;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
    localparam logic [IDX_W-1:0] G_IDX = IDX_W'(g);

    logic                  apb_hit;
    logic                  hw_hit;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] apb_merged;
    logic [DATA_WIDTH-1:0] hw_merged;

    assign apb_hit    = wr_commit && (wr_idx == G_IDX);
    assign hw_hit     = hw_valid && (hw_addr == G_IDX);
    assign apb_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(q),
                                               MAX_DATA_WIDTH'(wr_data),
                                               MAX_STRB_WIDTH'(wr_strb)));
    assign hw_merged  = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(q),
                                               MAX_DATA_WIDTH'(hw_wdata),
                                               MAX_STRB_WIDTH'(hw_wstrb)));

    // APB has priority: on a same-register collision the whole hardware
    // write is discarded rather than merged byte by byte.
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH];
      end else if (apb_hit) begin
        q <= apb_merged;
      end else if (hw_hit) begin
        q <= hw_merged;
      end
    end

    assign apb_hit_vec[g]                        = apb_hit;
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_pulse <= '0;
      hw_collision <= 1'b0;
    end else begin
      reg_wr_pulse <= apb_hit_vec;
      hw_collision <= wr_commit && hw_valid && (hw_addr == wr_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_register_file
// Description : Self-checking bench for apb_register_file. Directed cases
//               followed by randomized APB and hardware traffic, compared
//               against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_register_file;

  localparam int                ADDR_WIDTH = 12;
  localparam int                DATA_WIDTH = 32;
  localparam int                REG_NUM    = 8;
  localparam logic [7:0]        RO         = 8'h80;
  localparam logic [255:0]      RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                      32'h0, 32'hA5A5_0000, 32'hFFFF_FFFF, 32'h0};

  logic         clk;
  logic         reset;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic         hw_wen;
  logic [2:0]   hw_addr;
  logic [31:0]  hw_wdata;
  logic [3:0]   hw_wstrb;
  logic [255:0] regs_out;
  logic [7:0]   reg_wr_pulse;
  logic         hw_collision;

  apb_register_file #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .REG_NUM     (REG_NUM),
    .RO_MASK     (RO),
    .RESET_VALUE (RV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .hw_wen       (hw_wen),
    .hw_addr      (hw_addr),
    .hw_wdata     (hw_wdata),
    .hw_wstrb     (hw_wstrb),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse),
    .hw_collision (hw_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one 32-bit word per register.
  logic [31:0] m [REG_NUM];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < REG_NUM; i++) f[i*32 +: 32] = m[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) m[i] = RV[i*32 +: 32];
  endtask

  // Full APB transfer starting at a negedge (setup phase). An optional
  // hardware write is presented on the same edge as the APB commit.
  // Returns at the negedge of T3 with the bus idle, so calling it again
  // immediately produces back-to-back transfers.
  task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input bit hen, input logic [2:0] ha,
                          input logic [31:0] hd, input logic [3:0] hs);
    int          idx;
    bit          oor, err, commit, coll;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pulse;
    oor    = (addr >= 12'd32);
    idx    = int'(addr >> 2);
    err    = oor || (wr && RO[idx[2:0]]);
    exp_rd = (!wr && !oor) ? m[idx[2:0]] : 32'h0;

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(negedge clk);
    chk("wait_pready", pready, 1'b0);
    chk("wait_pulse", reg_wr_pulse, 8'h0);
    penable = 1'b1;
    @(negedge clk);
    chk("resp_pready", pready, 1'b1);
    chk("resp_pslverr", pslverr, err);
    chk("resp_prdata", prdata, exp_rd);
    chk("resp_pulse", reg_wr_pulse, 8'h0);
    hw_wen = hen; hw_addr = ha; hw_wdata = hd; hw_wstrb = hs;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; hw_wen = 1'b0;

    commit    = wr && !err;
    coll      = 1'b0;
    exp_pulse = 8'h0;
    if (commit) begin
      m[idx[2:0]] = merge(m[idx[2:0]], wd, st);
      exp_pulse[idx[2:0]] = 1'b1;
    end
    if (hen) begin
      if (commit && (ha == idx[2:0])) coll = 1'b1;
      else m[ha] = merge(m[ha], hd, hs);
    end
    chk("post_pready", pready, 1'b0);
    chk("post_regs", regs_out, model_flat());
    chk("post_pulse", reg_wr_pulse, exp_pulse);
    chk("post_collision", hw_collision, coll);
  endtask

  task automatic hw_write(input logic [2:0] ha, input logic [31:0] hd, input logic [3:0] hs);
    hw_wen = 1'b1; hw_addr = ha; hw_wdata = hd; hw_wstrb = hs;
    @(negedge clk);
    hw_wen = 1'b0;
    m[ha] = merge(m[ha], hd, hs);
    chk("hw_regs", regs_out, model_flat());
    chk("hw_collision", hw_collision, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  bit          r_wr;
  logic [11:0] r_addr;
  logic [2:0]  r_ha;

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; hw_wen = 1'b0; hw_addr = '0; hw_wdata = '0; hw_wstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_regs", regs_out, RV);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_pulse", reg_wr_pulse, 8'h0);
    chk("rst_collision", hw_collision, 1'b0);

    // Read of the reset image
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, 3'd0, 32'h0, 4'h0);
    @(negedge clk);

    // Strobed write over an all-ones register
    apb_xfer(1'b1, 12'h004, 32'h1122_3344, 4'b0101, 1'b0, 3'd0, 32'h0, 4'h0);
    chk("reg1_merge", regs_out[63:32], 32'hFF22_FF44);
    chk("reg1_pulse", reg_wr_pulse, 8'b0000_0010);
    @(negedge clk);
    chk("reg1_pulse_gone", reg_wr_pulse, 8'h0);

    // Zero-strobe write: commits, pulses, data unchanged
    apb_xfer(1'b1, 12'h005, 32'h9999_9999, 4'b0000, 1'b0, 3'd0, 32'h0, 4'h0);

    // Read-only register refuses APB but accepts hardware
    apb_xfer(1'b1, 12'h01C, 32'h1234_5678, 4'hF, 1'b0, 3'd0, 32'h0, 4'h0);
    hw_write(3'd7, 32'hDEAD_BEEF, 4'hF);
    chk("reg7_hw", regs_out[255:224], 32'hDEAD_BEEF);
    @(negedge clk);

    // Out-of-range read and write
    apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 3'd0, 32'h0, 4'h0);
    apb_xfer(1'b1, 12'h020, 32'hFFFF_FFFF, 4'hF, 1'b0, 3'd0, 32'h0, 4'h0);

    // Collision: same index drops hardware write; different index keeps both
    apb_xfer(1'b1, 12'h00C, 32'h0000_0001, 4'hF, 1'b1, 3'd3, 32'h0000_0002, 4'hF);
    chk("coll_reg3", regs_out[127:96], 32'h0000_0001);
    apb_xfer(1'b1, 12'h00C, 32'h0000_0001, 4'hF, 1'b1, 3'd4, 32'h0000_0002, 4'hF);
    chk("nocoll_reg3", regs_out[127:96], 32'h0000_0001);
    chk("nocoll_reg4", regs_out[159:128], 32'h0000_0002);
    @(negedge clk);

    // Reset asserted during the WAIT phase of a write aborts it
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    chk("abort_pready", pready, 1'b0);
    chk("abort_regs", regs_out, RV);
    chk("abort_prdata", prdata, 32'h0);
    @(negedge clk);
    chk("abort_pready2", pready, 1'b0);
    chk("abort_regs2", regs_out, RV);
    chk("abort_pulse", reg_wr_pulse, 8'h0);

    // Back-to-back read then write at three-cycle cadence
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, 3'd0, 32'h0, 4'h0);
    apb_xfer(1'b1, 12'h000, 32'hCAFE_F00D, 4'hF, 1'b0, 3'd0, 32'h0, 4'h0);
    apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 3'd0, 32'h0, 4'h0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        hw_write(3'($urandom), $urandom, 4'($urandom));
      end else begin
        r_wr   = 1'($urandom);
        r_addr = 12'($urandom_range(0, 43));
        r_ha   = ($urandom_range(0, 1) == 1) ? r_addr[4:2] : 3'($urandom);
        apb_xfer(r_wr, r_addr, $urandom, 4'($urandom), 1'($urandom), r_ha,
                 $urandom, 4'($urandom));
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    @(negedge clk);
    chk("final_regs", regs_out, model_flat());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
